// File: rtl/switch_debouncer.sv
// Purpose: synchronise, debounce and edge-flag the raw slider-switch pins, one bit at a time.
// Latency: a steady new level lands on SW_stable DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running, every output registered.
module switch_debouncer #(
    parameter int DW              = 9,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [DW:0] SW_raw,
    output logic [DW:0] SW_stable,
    output logic [DW:0] SW_changed,
    output logic        any_change
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DW:0] sync1_q;
    logic [DW:0] sync2_q;
    logic        any_q;

    wire  [DW:0] stable_w;
    wire  [DW:0] changed_w;
    wire  [DW:0] changed_d_w;

    // Plain two-flop synchroniser; nothing may sit between the stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            any_q   <= 1'b0;
        end else begin
            sync1_q <= SW_raw;
            sync2_q <= sync1_q;
            any_q   <= |changed_d_w;
        end
    end

    for (genvar i = 0; i <= DW; i++) begin : g_bit
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             stable_q;
        logic             stable_d;
        logic             changed_q;
        logic             changed_d;
        logic             mismatch;

        assign mismatch = sync2_q[i] != stable_q;

        // Counter saturates at CNT_MAX by construction: reaching it accepts and clears.
        always_comb begin
            cnt_d     = '0;
            stable_d  = stable_q;
            changed_d = 1'b0;
            if (mismatch) begin
                if (cnt_q == CNT_MAX) begin
                    stable_d  = sync2_q[i];
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q     <= '0;
                stable_q  <= 1'b0;
                changed_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                stable_q  <= stable_d;
                changed_q <= changed_d;
            end
        end

        assign stable_w[i]    = stable_q;
        assign changed_w[i]   = changed_q;
        assign changed_d_w[i] = changed_d;
    end

    assign SW_stable  = stable_w;
    assign SW_changed = changed_w;
    assign any_change = any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Purpose: directed scoreboard bench for switch_debouncer with a short debounce window.
// Latency: expectations are queued per edge and compared 1 ns after each rising edge.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_switch_debouncer;

    localparam int DW = 9;

    logic          clk;
    logic          reset;
    logic [DW:0]   SW_raw;
    logic [DW:0]   SW_stable;
    logic [DW:0]   SW_changed;
    logic          any_change;

    typedef struct {
        string       tag;
        logic [DW:0] st;
        logic [DW:0] ch;
        logic        an;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    switch_debouncer #(
        .DW              (DW),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SW_raw     (SW_raw),
        .SW_stable  (SW_stable),
        .SW_changed (SW_changed),
        .any_change (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [DW:0] st, input logic [DW:0] ch, input logic an);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ch  = ch;
        e.an  = an;
        exp_q.push_back(e);
    endtask

    // Queue n identical quiet cycles holding the given stable value.
    task automatic push_quiet(input string tag, input logic [DW:0] st, input int n);
        for (int k = 0; k < n; k++) push(tag, st, '0, 1'b0);
    endtask

    // One rising edge per queued entry; compare just after the edge.
    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            assert (SW_stable === e.st) else begin
                errors++;
                $error("FAIL %s SW_stable got %h want %h", e.tag, SW_stable, e.st);
            end
            checks++;
            assert (SW_changed === e.ch) else begin
                errors++;
                $error("FAIL %s SW_changed got %h want %h", e.tag, SW_changed, e.ch);
            end
            checks++;
            assert (any_change === e.an) else begin
                errors++;
                $error("FAIL %s any_change got %b want %b", e.tag, any_change, e.an);
            end
        end
    endtask

    initial begin
        // 1: reset held three edges with all switches high
        reset  = 1'b1;
        SW_raw = 10'h3FF;
        push_quiet("reset", 10'h000, 3);
        drain();
        reset  = 1'b0;
        SW_raw = 10'h000;
        push_quiet("idle", 10'h000, 3);
        drain();

        // 2: bit 0 rises, accepted on edge 6, single-cycle pulse
        SW_raw = 10'h001;
        push_quiet("b0_wait", 10'h000, 5);
        push("b0_accept", 10'h001, 10'h001, 1'b1);
        push_quiet("b0_after", 10'h001, 3);
        drain();

        // 3: bit 3 glitch of 3 cycles is rejected
        SW_raw = 10'h009;
        push_quiet("b3_glitch", 10'h001, 3);
        drain();
        SW_raw = 10'h001;
        push_quiet("b3_reject", 10'h001, 6);
        drain();
        // counter was cleared: a held level still needs the full six edges
        SW_raw = 10'h009;
        push_quiet("b3_full_wait", 10'h001, 5);
        push("b3_accept", 10'h009, 10'h008, 1'b1);
        push_quiet("b3_after", 10'h009, 1);
        drain();
        SW_raw = 10'h000;
        push_quiet("fall_wait", 10'h009, 5);
        push("fall_accept", 10'h000, 10'h009, 1'b1);
        push_quiet("fall_after", 10'h000, 2);
        drain();

        // 4: bits 0 and 9 rise together
        SW_raw = 10'h201;
        push_quiet("b09_wait", 10'h000, 5);
        push("b09_accept", 10'h201, 10'h201, 1'b1);
        push_quiet("b09_after", 10'h201, 2);
        drain();

        // 5: bit 5 rises (others fall), reset pulsed on edge 3
        SW_raw = 10'h020;
        push_quiet("b5_pre", 10'h201, 2);
        drain();
        reset = 1'b1;
        push_quiet("b5_reset", 10'h000, 1);
        drain();
        reset = 1'b0;
        push_quiet("b5_wait", 10'h000, 5);
        push("b5_accept", 10'h020, 10'h020, 1'b1);
        push_quiet("b5_after", 10'h020, 2);
        drain();

        // 6: bit 2 bounces 1,0,1,0 every 2 cycles, then holds 1
        for (int b = 0; b < 4; b++) begin
            SW_raw = (b % 2 == 0) ? 10'h024 : 10'h020;
            push_quiet("b2_bounce", 10'h020, 2);
            drain();
        end
        SW_raw = 10'h024;
        push_quiet("b2_wait", 10'h020, 5);
        push("b2_accept", 10'h024, 10'h004, 1'b1);
        push_quiet("b2_after", 10'h024, 4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
